// File: rtl/encode_scan.sv
// Sequential bit-scan encoder: emits the index of every set bit of an accepted vector, one per beat.
// Define ENCODE_SCAN_MSB_FIRST_EN to scan from the highest set bit down instead of LSB-first.
module encode_scan #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         out_last,
  output logic         zero
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state, state_nxt;
  logic [N-1:0]   pend, pend_nxt;
  logic           zero_nxt;
  logic [W-1:0]   idx;
  logic [N-1:0]   clr;
  logic           single;
  logic           accept;
  logic           beat;

  // Index of the bit serviced next; the last matching iteration wins.
  function automatic logic [W-1:0] next_idx(input logic [N-1:0] p);
    logic [W-1:0] r;
    r = '0;
`ifdef ENCODE_SCAN_MSB_FIRST_EN
    for (int i = 0; i < N; i++)
      if (p[i]) r = W'(i);
`else
    for (int i = N - 1; i >= 0; i--)
      if (p[i]) r = W'(i);
`endif
    return r;
  endfunction

  always_comb begin
    idx    = next_idx(pend);
    single = ((pend & (pend - ONE)) == '0);
    clr    = '0;
    for (int i = 0; i < N; i++)
      clr[i] = (W'(i) == idx);
  end

  // State and pending-vector register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      zero  <= zero_nxt;
    end
  end

  // Next state: retire the current bit, then a same-cycle accept overrides
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    zero_nxt  = 1'b0;
    if (beat) begin
      pend_nxt = pend & ~clr;
      if (out_last) state_nxt = IDLE;
    end
    if (accept) begin
      if (|in) begin
        pend_nxt  = in;
        state_nxt = SCAN;
      end else begin
        zero_nxt = 1'b1;
      end
    end
  end

  // Outputs; in_ready sees out_ready combinationally for bubble-free back-to-back vectors
  always_comb begin
    out_valid = en && (state == SCAN);
    out       = out_valid ? idx : '0;
    out_last  = out_valid && single;
    in_ready  = en && ((state == IDLE) || (out_valid && out_ready && out_last));
    accept    = in_valid && in_ready;
    beat      = out_valid && out_ready;
  end

endmodule

// File: tb/tb_encode_scan.sv
// Bench for encode_scan: directed scenarios then random traffic, checked against a queue-based model.
module tb_encode_scan;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk;
  logic         rst;
  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         out_last;
  logic         zero;

  encode_scan #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_last  (out_last),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int q[$];        // indices still to be emitted for the current vector, in scan order
  bit zflag = 0;
  bit armed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input logic [N-1:0] v);
    q.delete();
`ifdef ENCODE_SCAN_MSB_FIRST_EN
    for (int i = N - 1; i >= 0; i--) if (v[i]) q.push_back(i);
`else
    for (int i = 0; i < N; i++) if (v[i]) q.push_back(i);
`endif
  endtask

  task automatic step(input logic r, input logic e, input logic iv,
                      input logic [N-1:0] v, input logic ordy);
    bit ev, el, er, acc, bt;
    int eo;
    rst = r; en = e; in_valid = iv; in = v; out_ready = ordy;
    @(negedge clk);
    ev  = e && (q.size() > 0);
    eo  = ev ? q[0] : 0;
    el  = ev && (q.size() == 1);
    er  = e && ((q.size() == 0) || (ev && ordy && el));
    acc = iv && er;
    bt  = ev && ordy;
    if (armed) begin
      check("out_valid", 32'(out_valid), 32'(ev));
      check("out",       32'(out),       32'(eo));
      check("out_last",  32'(out_last),  32'(el));
      check("in_ready",  32'(in_ready),  32'(er));
      check("zero",      32'(zero),      32'(zflag));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      zflag = 0;
      armed = 1;
    end else begin
      zflag = 0;
      if (bt) void'(q.pop_front());
      if (acc) begin
        if (v != '0) load(v);
        else zflag = 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, ordy);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b0;
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    idle(1, 1'b1);

    // scan order with free-flowing consumer
    step(1'b0, 1'b1, 1'b1, 8'b1010_0110, 1'b1);
    idle(5, 1'b1);

    // backpressure: first index held for three cycles
    step(1'b0, 1'b1, 1'b1, 8'b1010_0110, 1'b0);
    idle(3, 1'b0);
    idle(5, 1'b1);

    // all-zero vector
    step(1'b0, 1'b1, 1'b1, 8'b0000_0000, 1'b1);
    idle(3, 1'b1);

    // back-to-back single-bit vectors, second offered on the last beat
    step(1'b0, 1'b1, 1'b1, 8'b0000_0001, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'b1000_0000, 1'b1);
    idle(2, 1'b1);

    // freeze after the first beat; offered vector must not be taken
    step(1'b0, 1'b1, 1'b1, 8'b0001_0011, 1'b1);
    idle(1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    idle(4, 1'b1);

    // zero pulse cut by freeze
    step(1'b0, 1'b1, 1'b1, 8'b0000_0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1, 1'b1);

    // reset mid-scan
    step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    idle(3, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, e, iv, ordy;
      logic [N-1:0] v;
      r    = ($urandom_range(0, 199) == 0);
      e    = ($urandom_range(0, 9) != 0);
      iv   = ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      v    = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      step(r, e, iv, v, ordy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encode_scan.md
# encode_scan

Parametrised sequential bit-scan encoder. It accepts an N-bit request vector over a valid/ready handshake and emits the binary index of every set bit, one index per accepted output beat. Scan order is LSB-first by default. It generalises the fixed 4-to-2 one-hot encoder in the encode library to arbitrary width and multi-hot input. It sits between request-collecting logic and any consumer that services requests one at a time.

## Interface
- N, default 8: input vector width; N ≥ 2.
- W, default $clog2(N): index width (derived; do not override).
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: block enable; 0 freezes the block.
- in_valid, input, 1: a request vector is presented.
- in_ready, output, 1: the block can accept a vector.
- in, input, N: request vector.
- out_valid, output, 1: out and out_last are valid.
- out_ready, input, 1: the consumer accepts the current index.
- out, output, W: binary index of the current set bit.
- out_last, output, 1: out is the final set bit of the current vector.
- zero, output, 1: one-cycle pulse; an all-zero vector was accepted.

## Operation
- State machine has two states, IDLE and SCAN. It holds an N-bit pending register P.
- in_ready = en && (state==IDLE || (out_valid && out_ready && out_last)).
  - The last-beat term is a combinational path from out_ready to in_ready. It gives back-to-back vectors with no bubble.
- Input accept happens when in_valid && in_ready:
  - in != 0: P <= in, and the next state is SCAN.
  - in == 0: zero <= 1 for one cycle, the state stays IDLE, and nothing is emitted.
- In SCAN with en=1:
  - out_valid = 1.
  - out = index of the lowest set bit of P.
  - out_last = 1 iff P has exactly one bit set.
- Output beat happens when out_valid && out_ready. The bit at index out is cleared in P.
  - If out_last is 1, the next state is IDLE, unless a new vector is accepted in the same cycle. In that case P <= in and the state stays SCAN, or goes to IDLE with a zero pulse if in==0.
- out and out_last are held stable while out_valid && !out_ready.
- en=0:
  - in_ready=0 and out_valid=0. P and the state are retained.
  - zero is 0 from the next edge.
  - Scanning resumes unchanged when en returns to 1.
- When out_valid=0, out and out_last are driven to 0, not X.

## Timing
- Reset values: state=IDLE, P=0, out_valid=0, out=0, out_last=0, zero=0.
- in_ready is 1 in the cycle after rst is released, provided en=1.
- Reset asserted mid-SCAN discards P. No further beats are emitted.
- Latency: a vector accepted at edge k gives out_valid=1 in the cycle after edge k. The first index is available then.
- Throughput: a vector with popcount c takes exactly c output beats with out_ready held at 1.
  - The next vector can be accepted on the last beat's edge.
  - Sustained rate is one index per cycle.
- zero is asserted in the cycle after the accept edge and lasts exactly one cycle.
- Width rules:
  - Index arithmetic is W bits wide.
  - N need not be a power of 2. Index values ≥ N never occur.

## Configuration
- ENCODE_SCAN_MSB_FIRST_EN
  - Undefined (default): LSB-first. out is the lowest set index of P.
  - Defined: MSB-first. out is the highest set index of P, and the highest bit is cleared each beat.
- out_last, zero, the handshake and the timing are identical in both builds.

## Test plan
- LSB-first ordering: N=8, in=8'b1010_0110, out_ready=1.
  - Required: out = 1, 2, 5, 7 on four consecutive cycles, with out_last=1 only on 7. Then in_ready=1.
- Backpressure: same vector, out_ready=0 for 3 cycles, then 1.
  - Required: out=1 held stable with out_valid=1 for all 3 cycles, then the sequence 1, 2, 5, 7 as above.
- Zero vector: in=0 accepted.
  - Required: zero=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
- Back-to-back vectors: in=8'b0000_0001, then 8'b1000_0000 presented on the last-beat cycle.
  - Required: out=0 (last), then out=7 (last) on the next cycle, with no bubble.
- Freeze and reset:
  - en=0 after the first beat of 8'b0001_0011: out_valid=0 while en=0; after en=1, out resumes at 1, then 4.
  - rst mid-SCAN: out_valid=0 in the cycle after the reset edge, no further beats, then in_ready=1.
- MSB-first build (ENCODE_SCAN_MSB_FIRST_EN defined), N=5, in=5'b10011.
  - Required: out = 4, 1, 0, with out_last on 0.
